lvds_word_align_fsm: RTL and testbench
======================================

Name: lvds_word_align_fsm

Overview:
- Parametrised word-alignment controller for 7:1 LVDS receive (and other N:1 ratios).
- Monitors the deserialized clock-lane word and issues single-cycle slip pulses to the deserializer until the word equals the expected clock pattern.
- Declares lock only after a qualified run of matches, leaves lock after a run of misses, and flags failure when the slip budget is exhausted.
- Sits between the IDDR-type deserializer (sclk domain) and the RX channel/lane logic.

Parameters:
- WORD_W, 7, deserialized word width (serialization ratio).
- CLK_PATTERN, 7'b1100011, expected clock-lane word; width WORD_W (7'b1100001 for the alternate transmitter).
- SETTLE_CYC, 4, cycles to ignore clock_word after each slip; must be >=1.
- LOCK_CNT, 8, consecutive matches required to assert locked; must be >=1.
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that drop lock; must be >=1.
- MAX_SLIPS, 14, slips allowed per alignment attempt before FAIL (default 2*WORD_W); must be >=1.

Ports:
- clk, in, 1, sclk (deserializer word clock).
- rst, in, 1, reset.
- align_enable, in, 1, level enable; low aborts and clears.
- clock_word, in, WORD_W, deserializer output for the clock lane.
- slip, out, 1, one-cycle slip command to the deserializer.
- locked, out, 1, qualified word lock.
- align_fail, out, 1, sticky failure (slip budget exhausted).
- word_match, out, 1, registered raw compare (clock_word==CLK_PATTERN), independent of state.
- slip_count, out, clog2(MAX_SLIPS+1), slips issued in the current attempt.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: state IDLE; slip, locked, align_fail, word_match = 0; slip_count and all internal counters = 0.
- All outputs are registered. Equality compares the unregistered clock_word input in the current cycle.
- align_enable low (any state): next state IDLE; slip=0, locked=0, align_fail=0; slip_count, match_cnt, miss_cnt, settle_cnt cleared. Takes priority over every transition below. word_match keeps tracking.
- IDLE: align_enable high -> CHECK.
- CHECK:
  - match -> VERIFY with match_cnt=1; if LOCK_CNT==1, go directly to LOCKED.
  - mismatch and slip_count==MAX_SLIPS -> FAIL.
  - mismatch otherwise -> SLIP.
- SLIP: lasts exactly 1 cycle.
  - The slip register is high for the clock period following entry; the deserializer therefore sees exactly one high cycle per slip.
  - slip_count increments (never exceeds MAX_SLIPS).
  - settle_cnt loaded with SETTLE_CYC; next state SETTLE.
- SETTLE: clock_word ignored; settle_cnt decrements; when it reaches 0 -> CHECK. The SETTLE dwell is exactly SETTLE_CYC cycles.
- VERIFY:
  - match: match_cnt+1; reaching LOCK_CNT -> LOCKED, with locked=1 from the next cycle.
  - mismatch: match_cnt=0, then same decision as a CHECK mismatch (FAIL if budget exhausted, else SLIP).
- LOCKED:
  - locked=1.
  - match clears miss_cnt.
  - mismatch increments miss_cnt; at UNLOCK_CNT -> locked=0, slip_count=0, miss_cnt=0, next state CHECK (fresh slip budget).
- FAIL: align_fail=1, slip=0, locked=0. Held until align_enable low or rst; no further slips.
- Latency with pattern present at enable, enable sampled high at edge E0:
  - CHECK during E0..E1.
  - The LOCK_CNT-th match is sampled at edge E(LOCK_CNT).
  - locked is high after edge E(LOCK_CNT+1).
- Minimum spacing between slip pulses: SETTLE_CYC+2 cycles.
- Each slip pulse is exactly 1 cycle wide; slip is never high in two consecutive cycles.

Decomposition:
- Shared package/include lvds_rx_pkg holds:
  - state encoding localparams: IDLE, CHECK, SLIP, SETTLE, VERIFY, LOCKED, FAIL (3-bit);
  - standard pattern constants RX_CLK_PT_1100011 and RX_CLK_PT_1100001;
  - default timing constants.
- No sub-module; the FSM and its counters are inline.
- One instance per clock lane. Data lanes reuse the resulting slip via the top level.

Test Plan:
- Pattern-correct at enable (clock_word=7'b1100011 constant, defaults) -> no slip; locked rises 9 cycles after enable sampled high; slip_count=0.
- Deserializer model rotating the word left 1 bit per slip, initial offset 3 -> exactly 3 one-cycle slip pulses spaced 6 cycles apart; then locked=1; slip_count=3.
- Pattern never appears (clock_word=7'h00) -> 14 slips; then align_fail=1, slip stays 0; align_enable low for 1 cycle -> align_fail=0, slip_count=0.
- In LOCKED, inject 3 mismatches, then 1 match, then 3 mismatches -> locked stays 1. Then 4 consecutive mismatches -> locked=0 next cycle, state CHECK, slip_count reset to 0.
- Glitch during VERIFY (5 matches, 1 mismatch) -> one slip issued, match_cnt restarts; lock requires 8 fresh matches.
- rst asserted mid-SLIP and align_enable dropped mid-SETTLE -> all outputs 0 immediately (async) / next cycle respectively; no residual slip pulse.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive path: alignment FSM states,
// standard clock-lane patterns and default timing values.
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    VERIFY = 3'd4,
    LOCKED = 3'd5,
    FAIL   = 3'd6
  } align_state_e;

  // Clock-lane words seen on a correctly aligned 7:1 link.
  localparam logic [6:0] RX_CLK_PT_1100011 = 7'b1100011;
  localparam logic [6:0] RX_CLK_PT_1100001 = 7'b1100001;

  localparam int unsigned DEF_WORD_W     = 7;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_LOCK_CNT   = 8;
  localparam int unsigned DEF_UNLOCK_CNT = 4;
  localparam int unsigned DEF_MAX_SLIPS  = 2 * DEF_WORD_W;

endpackage

// File: rtl/lvds_word_align_fsm.sv
// Word-alignment controller for one LVDS clock lane. Slips the deserializer
// until the clock-lane word matches the expected pattern, qualifies lock over
// a run of matches and drops it after a run of misses.
//
// state  | meaning
// IDLE   | disabled, counters clear
// CHECK  | compare clock_word once, decide verify / slip / fail
// SLIP   | one-cycle slip request to the deserializer
// SETTLE | ignore clock_word while the deserializer re-aligns
// VERIFY | counting consecutive matches toward lock
// LOCKED | aligned; counting consecutive misses toward unlock
// FAIL   | slip budget exhausted, held until disable
module lvds_word_align_fsm
  import lvds_rx_pkg::*;
#(
  parameter int unsigned       WORD_W      = DEF_WORD_W,
  parameter logic [WORD_W-1:0] CLK_PATTERN = WORD_W'(RX_CLK_PT_1100011),
  parameter int unsigned       SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned       LOCK_CNT    = DEF_LOCK_CNT,
  parameter int unsigned       UNLOCK_CNT  = DEF_UNLOCK_CNT,
  parameter int unsigned       MAX_SLIPS   = DEF_MAX_SLIPS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               align_enable,
  input  logic [WORD_W-1:0]                  clock_word,
  output logic                               slip,
  output logic                               locked,
  output logic                               align_fail,
  output logic                               word_match,
  output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count
);

  localparam int unsigned CNT_W    = $clog2(MAX_SLIPS + 1);
  localparam int unsigned MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W   = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

  align_state_e        state_q, state_d;
  logic [CNT_W-1:0]    slip_cnt_q, slip_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                slip_q, slip_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;
  logic                match_q;
  logic                is_match;
  logic                budget_gone;

  assign is_match    = (clock_word == CLK_PATTERN);
  assign budget_gone = (slip_cnt_q == CNT_W'(MAX_SLIPS));

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d      = state_q;
    slip_cnt_d   = slip_cnt_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    settle_cnt_d = settle_cnt_q;
    if (!align_enable) begin
      state_d      = IDLE;
      slip_cnt_d   = '0;
      match_cnt_d  = '0;
      miss_cnt_d   = '0;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = CHECK;
        CHECK: begin
          if (is_match) begin
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
            end else begin
              state_d     = VERIFY;
              match_cnt_d = MATCH_W'(1);
            end
          end else begin
            state_d = budget_gone ? FAIL : SLIP;
          end
        end
        SLIP: begin
          if (!budget_gone) slip_cnt_d = slip_cnt_q + 1'b1;
          settle_cnt_d = SETTLE_W'(SETTLE_CYC);
          state_d      = SETTLE;
        end
        SETTLE: begin
          settle_cnt_d = settle_cnt_q - 1'b1;
          if (settle_cnt_q <= SETTLE_W'(1)) begin
            settle_cnt_d = '0;
            state_d      = CHECK;
          end
        end
        VERIFY: begin
          if (is_match) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              match_cnt_d = '0;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = budget_gone ? FAIL : SLIP;
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == MISS_W'(UNLOCK_CNT - 1)) begin
            miss_cnt_d = '0;
            slip_cnt_d = '0;
            state_d    = CHECK;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
    // slip is high exactly while in SLIP; locked only while staying in LOCKED,
    // so it rises the cycle after entry and falls on the dropping miss.
    slip_d   = (state_d == SLIP);
    locked_d = (state_q == LOCKED) && (state_d == LOCKED);
    fail_d   = (state_d == FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slip_cnt_q   <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      settle_cnt_q <= '0;
      slip_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slip_cnt_q   <= slip_cnt_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      slip_q       <= slip_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
      match_q      <= is_match;
    end
  end

  assign slip       = slip_q;
  assign locked     = locked_q;
  assign align_fail = fail_q;
  assign word_match = match_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: tb/tb_lvds_word_align_fsm.sv
// Self-checking bench for lvds_word_align_fsm: a table of vectors, hand-written
// corner sequences, and a randomized run against a behavioural model.
module tb_lvds_word_align_fsm;

  localparam logic [6:0] PAT     = 7'b1100011;
  localparam int         SETTLE  = 4;
  localparam int         LOCKN   = 8;
  localparam int         UNLOCKN = 4;
  localparam int         MAXS    = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       align_enable;
  logic [6:0] clock_word;
  logic       slip, locked, align_fail, word_match;
  logic [3:0] slip_count;

  int n_chk = 0;
  int n_err = 0;
  bit mdl_on = 1'b0;

  lvds_word_align_fsm #(
    .WORD_W(7), .CLK_PATTERN(PAT), .SETTLE_CYC(SETTLE),
    .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN), .MAX_SLIPS(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .align_enable(align_enable), .clock_word(clock_word),
    .slip(slip), .locked(locked), .align_fail(align_fail),
    .word_match(word_match), .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [6:0] rotl(input logic [6:0] w);
    return {w[5:0], w[6]};
  endfunction

  function automatic logic [6:0] rotr(input logic [6:0] w);
    return {w[0], w[6:1]};
  endfunction

  // Reference model: alignment seen as "hunting" for a run of matches, a blind
  // window after every slip, a locked phase counting misses, and a failed phase.
  localparam int MD_IDLE = 0, MD_HUNT = 1, MD_BLIND = 2, MD_LOCK = 3, MD_FAIL = 4;
  int m_mode, m_run, m_miss, m_blind, m_slips;
  bit e_slip, e_locked, e_fail, e_match;
  wire hit = (clock_word == PAT);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= MD_IDLE; m_run <= 0; m_miss <= 0; m_blind <= 0; m_slips <= 0;
      e_slip <= 0; e_locked <= 0; e_fail <= 0; e_match <= 0;
    end else begin
      e_match  <= hit;
      e_slip   <= 1'b0;
      e_locked <= 1'b0;
      e_fail   <= 1'b0;
      if (!align_enable) begin
        m_mode <= MD_IDLE; m_run <= 0; m_miss <= 0; m_blind <= 0; m_slips <= 0;
      end else begin
        case (m_mode)
          MD_IDLE: m_mode <= MD_HUNT;
          MD_HUNT: begin
            if (hit) begin
              if (m_run + 1 >= LOCKN) begin m_mode <= MD_LOCK; m_run <= 0; end
              else m_run <= m_run + 1;
            end else begin
              m_run <= 0;
              if (m_slips >= MAXS) begin m_mode <= MD_FAIL; e_fail <= 1'b1; end
              else begin m_mode <= MD_BLIND; m_blind <= SETTLE + 1; e_slip <= 1'b1; end
            end
          end
          MD_BLIND: begin
            if (m_blind == SETTLE + 1) m_slips <= m_slips + 1;
            if (m_blind == 1) m_mode <= MD_HUNT;
            m_blind <= m_blind - 1;
          end
          MD_LOCK: begin
            if (hit) begin
              m_miss <= 0; e_locked <= 1'b1;
            end else if (m_miss + 1 >= UNLOCKN) begin
              m_miss <= 0; m_slips <= 0; m_mode <= MD_HUNT;
            end else begin
              m_miss <= m_miss + 1; e_locked <= 1'b1;
            end
          end
          default: e_fail <= 1'b1;
        endcase
      end
    end
  end

  // Compare every cycle against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    if (mdl_on) begin
      chk("mdl_slip",   slip,       e_slip);
      chk("mdl_locked", locked,     e_locked);
      chk("mdl_fail",   align_fail, e_fail);
      chk("mdl_match",  word_match, e_match);
      chk("mdl_count",  slip_count, m_slips);
    end
  end

  typedef struct {
    bit         en;
    logic [6:0] w;
    bit         x_slip, x_locked, x_fail, x_match;
    int         x_cnt;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int   nsl, last, cyc, ndbl, nextra, seen_lock;
    bit   prev;
    logic [6:0] cur;

    tbl[0] = '{1'b0, PAT, 0, 0, 0, 1, 0};
    tbl[1] = '{1'b1, PAT, 0, 0, 0, 1, 0};
    for (int i = 2; i <= 9; i++) tbl[i] = '{1'b1, PAT, 0, 0, 0, 1, 0};
    tbl[10] = '{1'b1, PAT,   0, 1, 0, 1, 0};
    tbl[11] = '{1'b1, 7'h00, 0, 1, 0, 0, 0};
    tbl[12] = '{1'b0, PAT,   0, 0, 0, 1, 0};

    rst = 1'b1; align_enable = 1'b0; clock_word = 7'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_slip", slip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", align_fail, 0);
    chk("rst_match", word_match, 0);
    chk("rst_count", slip_count, 0);
    rst = 1'b0;
    mdl_on = 1'b1;

    // Pattern already present at enable: lock 9 cycles after enable sampled.
    for (int i = 0; i < 13; i++) begin
      align_enable = tbl[i].en;
      clock_word   = tbl[i].w;
      tick();
      chk($sformatf("tbl%0d_slip", i),   slip,       tbl[i].x_slip);
      chk($sformatf("tbl%0d_locked", i), locked,     tbl[i].x_locked);
      chk($sformatf("tbl%0d_fail", i),   align_fail, tbl[i].x_fail);
      chk($sformatf("tbl%0d_match", i),  word_match, tbl[i].x_match);
      chk($sformatf("tbl%0d_count", i),  slip_count, tbl[i].x_cnt);
    end

    // Rotating deserializer, initial offset 3.
    align_enable = 1'b1;
    clock_word = rotr(rotr(rotr(PAT)));
    nsl = 0; last = 0; cyc = 0; ndbl = 0; prev = 1'b0;
    while (!locked && cyc < 200) begin
      tick();
      cyc++;
      if (slip && prev) ndbl++;
      if (slip) begin
        if (nsl > 0) chk("rot_gap", cyc - last, SETTLE + 2);
        last = cyc;
        nsl++;
        clock_word = rotl(clock_word);
      end
      prev = slip;
    end
    chk("rot_locked", locked, 1);
    chk("rot_nslips", nsl, 3);
    chk("rot_count", slip_count, 3);
    chk("rot_double", ndbl, 0);

    // Misses while locked: runs shorter than UNLOCK_CNT hold lock.
    for (int i = 0; i < 3; i++) begin clock_word = 7'h00; tick(); chk("lk_miss_a", locked, 1); end
    clock_word = PAT; tick(); chk("lk_match", locked, 1);
    for (int i = 0; i < 3; i++) begin clock_word = 7'h00; tick(); chk("lk_miss_b", locked, 1); end
    clock_word = PAT; tick(); chk("lk_match2", locked, 1);
    for (int i = 0; i < 3; i++) begin clock_word = 7'h00; tick(); chk("lk_miss_c", locked, 1); end
    tick();
    chk("unlock_locked", locked, 0);
    chk("unlock_count", slip_count, 0);
    tick();
    chk("unlock_check_slip", slip, 1);

    // Pattern never present: budget exhausts, failure is sticky.
    align_enable = 1'b0; tick();
    chk("nf_clear", align_fail, 0);
    align_enable = 1'b1; clock_word = 7'h00;
    nsl = 0; cyc = 0;
    while (!align_fail && cyc < 400) begin
      tick();
      cyc++;
      if (slip) nsl++;
    end
    chk("nf_fail", align_fail, 1);
    chk("nf_nslips", nsl, MAXS);
    chk("nf_count", slip_count, MAXS);
    nextra = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (slip) nextra++; end
    chk("nf_no_slip", nextra, 0);
    chk("nf_sticky", align_fail, 1);
    align_enable = 1'b0; tick();
    chk("nf_dis_fail", align_fail, 0);
    chk("nf_dis_count", slip_count, 0);

    // Glitch in VERIFY: one slip, then 8 fresh matches needed.
    clock_word = PAT; align_enable = 1'b1; tick();
    for (int i = 0; i < 5; i++) tick();
    clock_word = 7'h00; tick();
    chk("gl_slip", slip, 1);
    clock_word = PAT; nextra = 0;
    for (int i = 0; i < 13; i++) begin tick(); if (slip) nextra++; end
    chk("gl_not_yet", locked, 0);
    tick();
    chk("gl_locked", locked, 1);
    chk("gl_one_slip", nextra, 0);
    chk("gl_count", slip_count, 1);

    // Async reset during SLIP, enable drop during SETTLE.
    align_enable = 1'b0; tick();
    clock_word = 7'h00; align_enable = 1'b1; tick();
    tick();
    chk("ar_slip_pre", slip, 1);
    rst = 1'b1;
    #1;
    chk("ar_slip", slip, 0);
    chk("ar_locked", locked, 0);
    chk("ar_fail", align_fail, 0);
    chk("ar_count", slip_count, 0);
    #1 rst = 1'b0;
    tick(); chk("ar_no_residual", slip, 0);
    tick(); chk("ar_slip_again", slip, 1);
    tick(); chk("ar_count1", slip_count, 1);
    tick();
    align_enable = 1'b0; tick();
    chk("en_slip", slip, 0);
    chk("en_count", slip_count, 0);
    nextra = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (slip) nextra++; end
    chk("en_no_slip", nextra, 0);

    // Randomized run against the model.
    seen_lock = 0;
    cur = PAT;
    align_enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 300 == 0) begin
        cur = ($urandom_range(0, 4) == 0) ? 7'h00 : PAT;
        for (int r = $urandom_range(0, 6); r > 0; r--) cur = rotr(cur);
      end
      align_enable = ($urandom_range(0, 99) != 0);
      clock_word = ($urandom_range(0, 15) == 0) ? 7'($urandom) : cur;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; #1 rst = 1'b0;
      end
      tick();
      if (slip) cur = rotl(cur);
      if (locked) seen_lock++;
    end
    chk("rnd_lock_seen", seen_lock > 0, 1);

    mdl_on = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
